// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ack handshake with a fixed number of wait states.
// One transaction in flight; requests are only taken while idle, anything else on req is ignored.
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;

  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              errp_q;

  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              in_err;
  logic              rsp_err;
  logic              rsp_we;
  logic [ADDR_W-1:0] rsp_idx;

  logic [31:0]       mem [DEPTH];

  // Misaligned, or any byte address beyond the end of the array.
  assign in_err = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    ack     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, before the capture registers load.
  always_comb begin
    rsp_err = errp_q;
    rsp_we  = we_q;
    rsp_idx = idx_q;
    if (state_q == S_IDLE) begin
      rsp_err = in_err;
      rsp_we  = we;
      rsp_idx = addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_d == S_RESP) begin
      err_d   = rsp_err;
      rdata_d = (rsp_err || rsp_we) ? 32'd0 : mem[rsp_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        idx_q   <= addr[ADDR_W+1:2];
        we_q    <= we;
        wdata_q <= wdata;
        be_q    <= be;
        errp_q  <= in_err;
      end
    end
  end

  // A reset during RESP forces IDLE asynchronously, so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !errp_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
